// File: rtl/operand_streamer_if.sv
// Operand-streamer bundle: a/b operand handshakes plus the two source-memory read ports.
interface operand_streamer_if #(
    parameter int DW  = 16,
    parameter int AAW = 26,
    parameter int KAW = 16
);
    logic           act_mem_re;
    logic [AAW-1:0] act_mem_addr;
    logic [DW-1:0]  act_mem_qout;
    logic           krn_mem_re;
    logic [KAW-1:0] krn_mem_addr;
    logic [DW-1:0]  krn_mem_qout;
    logic [DW-1:0]  a_input;
    logic           a_valid;
    logic           a_ready;
    logic [DW-1:0]  b_input;
    logic           b_valid;
    logic           b_ready;

    modport master (
        output act_mem_re, act_mem_addr, input act_mem_qout,
        output krn_mem_re, krn_mem_addr, input krn_mem_qout,
        output a_input, a_valid, input a_ready,
        output b_input, b_valid, input b_ready
    );

    modport slave (
        input act_mem_re, act_mem_addr, output act_mem_qout,
        input krn_mem_re, krn_mem_addr, output krn_mem_qout,
        input a_input, a_valid, output a_ready,
        input b_input, b_valid, output b_ready
    );
endinterface

// File: rtl/operand_streamer.sv
// Walks the conv loop nest and streams zero-padded activation/kernel pairs; first valid 1 cycle after
// start, 1 pair/cycle; a and b are accepted independently and the next pair is read only once both are taken.
module operand_streamer #(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int INPUT_NB_CHANNELS  = 64,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int KERNEL_SIZE        = 3,
    parameter int ACT_MEM_HEIGHT     = 1 << 26,
    parameter int KRN_MEM_HEIGHT     = 1 << 16
) (
    input  logic clk,
    input  logic rst_in,
    input  logic start,
    output logic running,
    output logic done,
    operand_streamer_if.master bus
);
    localparam int P   = (KERNEL_SIZE - 1) / 2;
    localparam int AAW = $clog2(ACT_MEM_HEIGHT);
    localparam int KAW = $clog2(KRN_MEM_HEIGHT);
    localparam int XW  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
    localparam int YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
    localparam int CIW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1;
    localparam int COW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
    localparam int KW  = (KERNEL_SIZE        > 1) ? $clog2(KERNEL_SIZE)        : 1;

    localparam logic [XW-1:0]  X_MAX  = XW'(FEATURE_MAP_WIDTH - 1);
    localparam logic [YW-1:0]  Y_MAX  = YW'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [CIW-1:0] CI_MAX = CIW'(INPUT_NB_CHANNELS - 1);
    localparam logic [COW-1:0] CO_MAX = COW'(OUTPUT_NB_CHANNELS - 1);
    localparam logic [KW-1:0]  K_MAX  = KW'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t         state;
    logic [YW-1:0]  y,  nxt_y;
    logic [XW-1:0]  x,  nxt_x;
    logic [COW-1:0] co, nxt_co;
    logic [CIW-1:0] ci, nxt_ci;
    logic [KW-1:0]  ky, nxt_ky;
    logic [KW-1:0]  kx, nxt_kx;
    logic           a_vld, b_vld, pad_q, nxt_pad;
    logic           carry, last, complete, issue;
    int             iy, ix;
    longint         act_full, krn_full;

    // Index of the pair to read next: zero from IDLE, otherwise the current index plus one.
    always_comb begin
        nxt_y  = y;
        nxt_x  = x;
        nxt_co = co;
        nxt_ci = ci;
        nxt_ky = ky;
        nxt_kx = kx;
        carry  = 1'b1;
        if (state == S_IDLE) begin
            nxt_y  = '0;
            nxt_x  = '0;
            nxt_co = '0;
            nxt_ci = '0;
            nxt_ky = '0;
            nxt_kx = '0;
        end else begin
            if (kx == K_MAX) nxt_kx = '0; else begin nxt_kx = kx + 1'b1; carry = 1'b0; end
            if (carry) begin
                if (ky == K_MAX) nxt_ky = '0; else begin nxt_ky = ky + 1'b1; carry = 1'b0; end
            end
            if (carry) begin
                if (ci == CI_MAX) nxt_ci = '0; else begin nxt_ci = ci + 1'b1; carry = 1'b0; end
            end
            if (carry) begin
                if (co == CO_MAX) nxt_co = '0; else begin nxt_co = co + 1'b1; carry = 1'b0; end
            end
            if (carry) begin
                if (x == X_MAX) nxt_x = '0; else begin nxt_x = x + 1'b1; carry = 1'b0; end
            end
            if (carry) begin
                if (y != Y_MAX) nxt_y = y + 1'b1;
                else nxt_y = '0;
            end
        end
    end

    always_comb begin
        iy       = int'(nxt_y) + int'(nxt_ky) - P;
        ix       = int'(nxt_x) + int'(nxt_kx) - P;
        nxt_pad  = (iy < 0) || (iy >= FEATURE_MAP_HEIGHT) || (ix < 0) || (ix >= FEATURE_MAP_WIDTH);
        act_full = (longint'(iy) * longint'(FEATURE_MAP_WIDTH) + longint'(ix))
                   * longint'(INPUT_NB_CHANNELS) + longint'(nxt_ci);
        krn_full = ((longint'(nxt_ky) * longint'(KERNEL_SIZE) + longint'(nxt_kx))
                   * longint'(INPUT_NB_CHANNELS) + longint'(nxt_ci))
                   * longint'(OUTPUT_NB_CHANNELS) + longint'(nxt_co);
    end

    assign last     = (y == Y_MAX) && (x == X_MAX) && (co == CO_MAX) &&
                      (ci == CI_MAX) && (ky == K_MAX) && (kx == K_MAX);
    assign complete = (state == S_STREAM) && (!a_vld || bus.a_ready) && (!b_vld || bus.b_ready);
    // Reads go out in the same cycle the previous pair completes so data lands with the new valids.
    assign issue    = !rst_in && (((state == S_IDLE) && start) || (complete && !last));

    assign bus.krn_mem_re   = issue;
    assign bus.krn_mem_addr = KAW'(krn_full);
    assign bus.act_mem_re   = issue && !nxt_pad;
    assign bus.act_mem_addr = AAW'(act_full);
    assign bus.a_valid      = a_vld;
    assign bus.b_valid      = b_vld;
    assign bus.a_input      = (running && !pad_q) ? bus.act_mem_qout : '0;
    assign bus.b_input      = bus.krn_mem_qout;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state   <= S_IDLE;
            y       <= '0;
            x       <= '0;
            co      <= '0;
            ci      <= '0;
            ky      <= '0;
            kx      <= '0;
            a_vld   <= 1'b0;
            b_vld   <= 1'b0;
            pad_q   <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state   <= S_STREAM;
                    running <= 1'b1;
                end
                S_STREAM: if (complete && last) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    running <= 1'b0;
                end
            endcase
            if (issue) begin
                y     <= nxt_y;
                x     <= nxt_x;
                co    <= nxt_co;
                ci    <= nxt_ci;
                ky    <= nxt_ky;
                kx    <= nxt_kx;
                pad_q <= nxt_pad;
                a_vld <= 1'b1;
                b_vld <= 1'b1;
            end else begin
                // An accepted channel stays quiet until its partner is taken too.
                a_vld <= a_vld && !bus.a_ready;
                b_vld <= b_vld && !bus.b_ready;
            end
        end
    end
endmodule
